truth_table_scanner: RTL and testbench

- Sequential stimulus/capture stage wrapped around the 4-input combinational lab block (inputs a, b, c, d; output x).
- Drives a, b, c, d through all 16 codes in ascending order, with `a` as the MSB.
- Holds each code for a programmable settle time, then samples x into a 16-bit truth-table register.
- The captured table feeds downstream display/check logic; this replaces hand-written vector lists in hardware.

---
 rtl/truth_table_scanner_if.sv | 22 ++
 rtl/truth_table_scanner.sv | 99 +++++++++
 tb/tb_truth_table_scanner.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if: stimulus/capture bundle between scanner and the block under scan; TT_EXPECT_CHECK_EN adds mismatch signals
interface truth_table_scanner_if;
  logic start;
  logic x;
  logic a;
  logic b;
  logic c;
  logic d;
  logic busy;
  logic done;
  logic table_valid;
  logic [15:0] table_out;
`ifdef TT_EXPECT_CHECK_EN
  logic mismatch;
  logic [15:0] mismatch_mask;
  modport master(output start, x, input a, b, c, d, busy, done, table_valid, table_out, mismatch, mismatch_mask);
  modport slave(input start, x, output a, b, c, d, busy, done, table_valid, table_out, mismatch, mismatch_mask);
`else
  modport master(output start, x, input a, b, c, d, busy, done, table_valid, table_out);
  modport slave(input start, x, output a, b, c, d, busy, done, table_valid, table_out);
`endif
endinterface

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks a..d through codes 0..15, samples x after SETTLE cycles per code into a 16-bit table; TT_EXPECT_CHECK_EN adds golden-table mismatch outputs
module truth_table_scanner #(
  parameter int SETTLE = 4,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input logic clk,
  input logic rst,
  truth_table_scanner_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;
  state_t state, state_n;
  logic [3:0] idx, idx_n;
  logic [7:0] cnt, cnt_n;
  logic [15:0] tbl, tbl_n;
  logic tv, tv_n;
  logic busy_q, done_q;
  logic last;
  logic accept;
  assign last = cnt == 8'(SETTLE - 1);
  assign accept = state == S_IDLE && bus.start;
  assign {bus.a, bus.b, bus.c, bus.d} = idx;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.table_valid = tv;
  assign bus.table_out = tbl;
  // next-state: settle counting, sampling on the last settle cycle, code advance
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    tbl_n = tbl;
    tv_n = tv;
    case (state)
      S_IDLE: if (bus.start) begin
        idx_n = 4'd0;
        cnt_n = 8'd0;
        tv_n = 1'b0;
        tbl_n = 16'h0000;
        state_n = S_SETTLE;
      end
      S_SETTLE: if (!last) cnt_n = cnt + 8'd1;
      else begin
        tbl_n[idx] = bus.x;
        if (idx == 4'd15) state_n = S_DONE;
        else begin
          idx_n = idx + 4'd1;
          cnt_n = 8'd0;
        end
      end
      S_DONE: begin
        tv_n = 1'b1;
        idx_n = 4'd0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
  // state and registered outputs; busy/done follow the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx <= 4'd0;
      cnt <= 8'd0;
      tbl <= 16'h0000;
      tv <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      tbl <= tbl_n;
      tv <= tv_n;
      busy_q <= state_n == S_SETTLE;
      done_q <= state_n == S_DONE;
    end
  end
`ifdef TT_EXPECT_CHECK_EN
  logic mm;
  logic [15:0] mmask;
  assign bus.mismatch = mm;
  assign bus.mismatch_mask = mmask;
  // compare the finished table against the golden one as the scan retires
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      mm <= 1'b0;
      mmask <= 16'h0000;
    end else if (state == S_DONE) begin
      mm <= |(tbl ^ EXPECTED);
      mmask <= tbl ^ EXPECTED;
    end
  end
`else
  logic unused_expected;
  logic unused_accept;
  assign unused_expected = ^EXPECTED;
  assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: directed checks of scan timing, captured tables, reset abort and back-to-back scans
module tb_truth_table_scanner;
  logic clk;
  logic rst;
  int mode;
  int checks;
  int errors;
  truth_table_scanner_if s4();
  truth_table_scanner_if s1();
  truth_table_scanner #(.SETTLE(4), .EXPECTED(16'hF000)) u4 (.clk(clk), .rst(rst), .bus(s4));
  truth_table_scanner #(.SETTLE(1), .EXPECTED(16'hAAAA)) u1 (.clk(clk), .rst(rst), .bus(s1));
  function automatic logic model(input int m, input logic [3:0] code);
    return m == 0 ? code[3] & code[2] : m == 1 ? code[0] : code[0] ^ (code == 4'd5);
  endfunction
  assign s4.x = model(mode, {s4.a, s4.b, s4.c, s4.d});
  assign s1.x = model(mode, {s1.a, s1.b, s1.c, s1.d});
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({s4.a, s4.b, s4.c, s4.d, s4.busy, s4.done, s4.table_valid} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 0000000", {s4.a, s4.b, s4.c, s4.d, s4.busy, s4.done, s4.table_valid});
    end
    checks++;
    if (s4.table_out !== 16'h0000 || s1.table_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_table got %h/%h exp 0000/0000", s4.table_out, s1.table_out);
    end
  endtask
  task automatic run_scan4(input string tag, input int repulse);
    logic [3:0] code;
    @(negedge clk);
    s4.start = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      s4.start = k == repulse;
      checks++;
      if (s4.busy !== (k <= 64)) begin
        errors++;
        $display("FAIL %s busy k=%0d got %b exp %b", tag, k, s4.busy, k <= 64);
      end
      checks++;
      if (s4.done !== (k == 65)) begin
        errors++;
        $display("FAIL %s done k=%0d got %b exp %b", tag, k, s4.done, k == 65);
      end
      code = k <= 64 ? 4'((k - 1) / 4) : 4'd0;
      if (k != 65) begin
        checks++;
        if ({s4.a, s4.b, s4.c, s4.d} !== code) begin
          errors++;
          $display("FAIL %s code k=%0d got %h exp %h", tag, k, {s4.a, s4.b, s4.c, s4.d}, code);
        end
      end
      if (k == 1) begin
        checks++;
        if (s4.table_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s valid_clear got %b exp 0", tag, s4.table_valid);
        end
      end
    end
    checks++;
    if (s4.table_out !== 16'hF000 || s4.table_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s table got %h/%b exp F000/1", tag, s4.table_out, s4.table_valid);
    end
  endtask
  task automatic run_scan1(input string tag, input logic [15:0] exp_tbl);
    @(negedge clk);
    s1.start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      s1.start = 1'b0;
      checks++;
      if (s1.busy !== (k <= 16) || s1.done !== (k == 17)) begin
        errors++;
        $display("FAIL %s busy_done k=%0d got %b%b exp %b%b", tag, k, s1.busy, s1.done, k <= 16, k == 17);
      end
      if (k <= 16) begin
        checks++;
        if ({s1.a, s1.b, s1.c, s1.d} !== 4'(k - 1)) begin
          errors++;
          $display("FAIL %s code k=%0d got %h exp %h", tag, k, {s1.a, s1.b, s1.c, s1.d}, 4'(k - 1));
        end
      end
    end
    checks++;
    if (s1.table_out !== exp_tbl || s1.table_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s table got %h/%b exp %h/1", tag, s1.table_out, s1.table_valid, exp_tbl);
    end
`ifdef TT_EXPECT_CHECK_EN
    checks++;
    if (s1.mismatch_mask !== (exp_tbl ^ 16'hAAAA) || s1.mismatch !== |(exp_tbl ^ 16'hAAAA)) begin
      errors++;
      $display("FAIL %s mismatch got %b/%h exp %b/%h", tag, s1.mismatch, s1.mismatch_mask, |(exp_tbl ^ 16'hAAAA), exp_tbl ^ 16'hAAAA);
    end
`endif
  endtask
  task automatic test_scan4();
    mode = 0;
    run_scan4("scan4", 0);
  endtask
  task automatic test_scan1();
    mode = 1;
    run_scan1("scan1", 16'hAAAA);
  endtask
  task automatic test_restart_ignored();
    mode = 0;
    run_scan4("restart", 10);
  endtask
  task automatic test_reset_mid();
    mode = 0;
    @(negedge clk);
    s4.start = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      s4.start = 1'b0;
    end
    checks++;
    if ({s4.a, s4.b, s4.c, s4.d} !== 4'd7 || s4.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got %h/%b exp 7/1", {s4.a, s4.b, s4.c, s4.d}, s4.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({s4.a, s4.b, s4.c, s4.d, s4.busy, s4.done, s4.table_valid} !== 7'd0 || s4.table_out !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset got %b/%h exp 0000000/0000", {s4.a, s4.b, s4.c, s4.d, s4.busy, s4.done, s4.table_valid}, s4.table_out);
    end
    run_scan4("after_rst", 0);
  endtask
  task automatic test_back_to_back();
    logic eb, ed;
    mode = 0;
    @(negedge clk);
    s4.start = 1'b1;
    for (int k = 1; k <= 132; k++) begin
      @(negedge clk);
      if (k == 68) s4.start = 1'b0;
      eb = (k >= 1 && k <= 64) || (k >= 67 && k <= 130);
      ed = k == 65 || k == 131;
      checks++;
      if (s4.busy !== eb || s4.done !== ed) begin
        errors++;
        $display("FAIL b2b k=%0d got %b%b exp %b%b", k, s4.busy, s4.done, eb, ed);
      end
    end
    checks++;
    if (s4.table_out !== 16'hF000 || s4.table_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_table got %h/%b exp F000/1", s4.table_out, s4.table_valid);
    end
  endtask
`ifdef TT_EXPECT_CHECK_EN
  task automatic test_mismatch();
    mode = 2;
    run_scan1("mm_bad", 16'hAA8A);
    mode = 1;
    run_scan1("mm_good", 16'hAAAA);
  endtask
`endif
  initial begin
    checks = 0;
    errors = 0;
    mode = 0;
    rst = 1'b1;
    s4.start = 1'b0;
    s1.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_scan4();
    test_reset();
    test_scan1();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef TT_EXPECT_CHECK_EN
    test_mismatch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
